flatten_feature_buffer: RTL and testbench

// Producer end of the classifier's input_ANN bus. Collects the pooled CNN feature stream (valid/ready, one word
// per cycle), scatters it into flattened (c,y,x) order, then holds the vector stable while driving the classifier's

---
 rtl/cnn_pkg.sv | 40 ++++
 rtl/flatten_index_gen.sv | 102 ++++++++++
 rtl/flatten_feature_buffer.sv | 152 +++++++++++++++
 tb/tb_flatten_feature_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN feature path: default geometry, class width,
// FSM state encoding and small width helpers.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 32;
    localparam int CNN_CHANNELS   = 16;
    localparam int CNN_HEIGHT     = 5;
    localparam int CNN_WIDTH      = 5;
    localparam int CNN_FEATURES   = CNN_CHANNELS * CNN_HEIGHT * CNN_WIDTH;
    localparam int CLASS_W        = 4;

    // FSM encoding kept as plain constants for legacy tools
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FILL   = 3'd1;
    localparam state_t ST_KICK   = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_REPORT = 3'd4;

    // Width of a counter that runs 0..n-1 (at least one bit)
    function automatic int dim_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Width able to hold max(a,b) inclusive
    function automatic int cnt_width(input int a, input int b);
        int m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/flatten_index_gen.sv
// Tracks the (c,y,x) position of the next arriving feature word and maps it to
// its flattened c-major linear index. The arrival order decides which counter
// runs fastest; the mapping to the linear index is the same in both orders.
module flatten_index_gen
    import cnn_pkg::*;
#(
    parameter int CHANNELS    = CNN_CHANNELS,
    parameter int HEIGHT      = CNN_HEIGHT,
    parameter int WIDTH       = CNN_WIDTH,
    parameter int INTERLEAVED = 0,
    localparam int FEATURES   = CHANNELS * HEIGHT * WIDTH,
    localparam int IDX_W      = dim_width(FEATURES)
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    localparam int C_W = dim_width(CHANNELS);
    localparam int Y_W = dim_width(HEIGHT);
    localparam int X_W = dim_width(WIDTH);

    logic [C_W-1:0] c_q, c_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [X_W-1:0] x_q, x_d;
    logic           c_last_s, y_last_s, x_last_s;

    assign c_last_s = (c_q == C_W'(CHANNELS - 1));
    assign y_last_s = (y_q == Y_W'(HEIGHT - 1));
    assign x_last_s = (x_q == X_W'(WIDTH - 1));

    assign idx_o  = IDX_W'(int'(c_q) * (HEIGHT * WIDTH) + int'(y_q) * WIDTH + int'(x_q));
    assign last_o = c_last_s & y_last_s & x_last_s;

    // Advance the position counters in arrival order, clear has priority
    always_comb begin
        c_d = c_q;
        y_d = y_q;
        x_d = x_q;
        if (clr_i) begin
            c_d = '0;
            y_d = '0;
            x_d = '0;
        end else if (adv_i) begin
            if (INTERLEAVED != 0) begin
                // y,x,c order: channel fastest, then column, then row
                if (c_last_s) begin
                    c_d = '0;
                    if (x_last_s) begin
                        x_d = '0;
                        if (y_last_s) begin
                            y_d = '0;
                        end else begin
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end else begin
                // c,y,x order: column fastest, then row, then channel
                if (x_last_s) begin
                    x_d = '0;
                    if (y_last_s) begin
                        y_d = '0;
                        if (c_last_s) begin
                            c_d = '0;
                        end else begin
                            c_d = c_q + C_W'(1);
                        end
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
        end else begin
            c_d = c_q;
        end
    end

    // Position counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= '0;
            y_q <= '0;
            x_q <= '0;
        end else begin
            c_q <= c_d;
            y_q <= y_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/flatten_feature_buffer.sv
// Producer side of the classifier input bus: gathers one pooled feature map
// into a flattened vector, holds it while the classifier runs, then captures
// the class index the classifier settled on.
module flatten_feature_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
    parameter int CHANNELS    = CNN_CHANNELS,
    parameter int HEIGHT      = CNN_HEIGHT,
    parameter int WIDTH       = CNN_WIDTH,
    parameter int INTERLEAVED = 0,
    parameter int HOLD_CYCLES = 1209,
    localparam int FEATURES   = CHANNELS * HEIGHT * WIDTH
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           abort,
    output logic [DATA_WIDTH*FEATURES-1:0] feat_vec,
    output logic                           ann_reset,
    input  logic [CLASS_W-1:0]             class_in,
    output logic [CLASS_W-1:0]             class_out,
    output logic                           class_valid
);

    localparam int CNT_W = cnt_width(FEATURES, HOLD_CYCLES);
    localparam int IDX_W = dim_width(FEATURES);

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     hold_cnt_q, hold_cnt_d;
    logic [FEATURES-1:0][DATA_WIDTH-1:0]  feat_q;
    logic                                 in_ready_q;
    logic                                 ann_reset_q;
    logic [CLASS_W-1:0]                   class_out_q;
    logic                                 class_valid_q;

    logic                                 abort_s;
    logic                                 xfer_s;
    logic                                 wr_en_s;
    logic                                 gen_clr_s;
    logic                                 report_s;
    logic [IDX_W-1:0]                     wr_idx_s;
    logic                                 last_s;

    // Abort is ignored in IDLE; it outranks both a word transfer and REPORT
    assign abort_s  = abort & (state_q != ST_IDLE);
    assign xfer_s   = in_valid & in_ready_q & (state_q == ST_FILL);
    assign wr_en_s  = xfer_s & ~abort_s;
    assign report_s = (state_q == ST_REPORT) & ~abort_s;

    flatten_index_gen #(
        .CHANNELS    (CHANNELS),
        .HEIGHT      (HEIGHT),
        .WIDTH       (WIDTH),
        .INTERLEAVED (INTERLEAVED)
    ) u_index_gen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (gen_clr_s),
        .adv_i  (wr_en_s),
        .idx_o  (wr_idx_s),
        .last_o (last_s)
    );

    // Sequencing: fill, one kick cycle, fixed hold window, report, refill
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gen_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (wr_en_s && last_s) begin
                    state_d = ST_KICK;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_KICK: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_REPORT: begin
                state_d    = ST_FILL;
                hold_cnt_d = '0;
                gen_clr_s  = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                gen_clr_s  = 1'b1;
            end
        endcase
        if (abort_s) begin
            state_d    = ST_FILL;
            hold_cnt_d = '0;
            gen_clr_s  = 1'b1;
        end else begin
            gen_clr_s  = gen_clr_s;
        end
    end

    // FSM, hold counter and registered handshake/class outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            in_ready_q    <= 1'b0;
            ann_reset_q   <= 1'b1;
            class_out_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            // Outputs are decoded from the next state so they line up with it
            in_ready_q    <= (state_d == ST_FILL);
            ann_reset_q   <= (state_d != ST_HOLD);
            class_valid_q <= report_s;
            if (report_s) begin
                class_out_q <= class_in;
            end
        end
    end

    // Feature storage: written only by accepted words, frozen otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            feat_q <= '0;
        end else if (wr_en_s) begin
            feat_q[wr_idx_s] <= in_data;
        end
    end

    assign in_ready    = in_ready_q;
    assign ann_reset   = ann_reset_q;
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;
    assign feat_vec    = feat_q;

endmodule

// File: tb/tb_flatten_feature_buffer.sv
// Scoreboard bench for flatten_feature_buffer: two instances (planar and
// interleaved arrival order), both with a short hold window.
module tb_flatten_feature_buffer;

    localparam int DW = 32;
    localparam int C  = 16;
    localparam int H  = 5;
    localparam int W  = 5;
    localparam int F  = C * H * W;
    localparam int HC = 10;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data0, in_data1;
    logic          in_valid0, in_valid1;
    logic          in_ready0, in_ready1;
    logic          abort0, abort1;
    logic [DW*F-1:0] feat0, feat1;
    logic          ann_reset0, ann_reset1;
    logic [3:0]    class_in;
    logic [3:0]    class_out0, class_out1;
    logic          class_valid0, class_valid1;

    int          n_checks = 0;
    int          n_fail   = 0;
    word_t       vec_q[$];
    logic [3:0]  cls_q[$];
    logic [31:0] model0 [F];

    always #5 clk = ~clk;

    flatten_feature_buffer #(.INTERLEAVED(0), .HOLD_CYCLES(HC)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .abort(abort0), .feat_vec(feat0), .ann_reset(ann_reset0),
        .class_in(class_in), .class_out(class_out0), .class_valid(class_valid0)
    );

    flatten_feature_buffer #(.INTERLEAVED(1), .HOLD_CYCLES(HC)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .abort(abort1), .feat_vec(feat1), .ann_reset(ann_reset1),
        .class_in(class_in), .class_out(class_out1), .class_valid(class_valid1)
    );

    // Drive nwords words (value base+k) into instance sel; push expected (index,value)
    // for every accepted word. Returns #1 after the edge that took the last word.
    task automatic stream(input int sel, input int ilv, input int nwords,
                          input logic [31:0] base, input int gap_pct);
        int    k = 0;
        int    budget = 0;
        int    c, y, x;
        logic  rdy, v;
        word_t w;
        while (k < nwords) begin
            @(negedge clk);
            rdy = (sel != 0) ? in_ready1 : in_ready0;
            v   = ($urandom_range(99) >= gap_pct);
            if (sel != 0) begin
                in_valid1 = v;
                in_data1  = base + k;
            end else begin
                in_valid0 = v;
                in_data0  = base + k;
            end
            if (v && rdy) begin
                if (ilv != 0) begin
                    c = k % C;
                    x = (k / C) % W;
                    y = k / (C * W);
                end else begin
                    x = k % W;
                    y = (k / W) % H;
                    c = k / (H * W);
                end
                w.idx = c * H * W + y * W + x;
                w.val = base + k;
                vec_q.push_back(w);
                if (sel == 0) model0[w.idx] = w.val;
                k++;
            end
            budget++;
            if (budget > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_timeout: accepted %0d words, required %0d", k, nwords);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready0); end
        n_checks++; if (ann_reset0 !== 1'b1) begin n_fail++; $display("FAIL rst_ann_reset: got %b want 1", ann_reset0); end
        n_checks++; if (class_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_class_valid: got %b want 0", class_valid0); end
        n_checks++; if (class_out0 !== 4'd0) begin n_fail++; $display("FAIL rst_class_out: got %0d want 0", class_out0); end
        n_checks++; if (feat0 !== '0) begin n_fail++; $display("FAIL rst_feat_vec: not all zero"); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        // IDLE lasts one cycle, after which the buffer is ready
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL idle_to_fill: in_ready got %b want 1", in_ready0); end
    endtask

    task automatic test_basic();
        word_t      w;
        logic [3:0] exp_c;
        int         low = 0, pulses = 0, pulse_at = -1, early = 0;
        class_in = 4'd7;
        stream(0, 0, F, 32'd0, 0);
        cls_q.push_back(4'd7);
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL kick_in_ready: got %b want 0", in_ready0); end
        n_checks++; if (ann_reset0 !== 1'b1) begin n_fail++; $display("FAIL kick_ann_reset: got %b want 1", ann_reset0); end
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (!ann_reset0) low++;
            if (in_ready0 && n < HC + 2) early++;
            if (class_valid0) begin
                pulses++;
                pulse_at = n;
                if (cls_q.size() > 0) begin
                    exp_c = cls_q.pop_front();
                    n_checks++;
                    if (class_out0 !== exp_c) begin n_fail++; $display("FAIL basic_class: got %0d want %0d", class_out0, exp_c); end
                end
            end
        end
        n_checks++; if (low != HC) begin n_fail++; $display("FAIL basic_ann_low: got %0d cycles want %0d", low, HC); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
        n_checks++; if (pulse_at != HC + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", pulse_at, HC + 2); end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL basic_ready_early: got %0d cycles want 0", early); end
        while (vec_q.size() > 0) begin
            w = vec_q.pop_front();
            n_checks++;
            if (feat0[DW*w.idx +: DW] !== w.val) begin
                n_fail++; $display("FAIL basic_vec word %0d: got %0d want %0d", w.idx, feat0[DW*w.idx +: DW], w.val);
            end
        end
    endtask

    task automatic test_interleaved();
        word_t       w;
        logic [31:0] wv;
        int          pulses = 0;
        class_in = 4'd10;
        stream(1, 1, F, 32'd0, 0);
        while (vec_q.size() > 0) begin
            w = vec_q.pop_front();
            n_checks++;
            if (feat1[DW*w.idx +: DW] !== w.val) begin
                n_fail++; $display("FAIL ilv_vec word %0d: got %0d want %0d", w.idx, feat1[DW*w.idx +: DW], w.val);
            end
        end
        wv = feat1[0 +: DW];
        n_checks++; if (wv !== 32'd0) begin n_fail++; $display("FAIL ilv_word0: got %0d want 0", wv); end
        wv = feat1[DW*1 +: DW];
        n_checks++; if (wv !== 32'd16) begin n_fail++; $display("FAIL ilv_word1: got %0d want 16", wv); end
        wv = feat1[DW*25 +: DW];
        n_checks++; if (wv !== 32'd1) begin n_fail++; $display("FAIL ilv_word25: got %0d want 1", wv); end
        wv = feat1[DW*399 +: DW];
        n_checks++; if (wv !== 32'd399) begin n_fail++; $display("FAIL ilv_word399: got %0d want 399", wv); end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (class_valid1) begin
                pulses++;
                n_checks++;
                if (class_out1 !== 4'd10) begin n_fail++; $display("FAIL ilv_class: got %0d want 10", class_out1); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ilv_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_gaps();
        word_t      w;
        logic [3:0] exp_c;
        int         pulses = 0;
        class_in = 4'd3;
        stream(0, 0, F, 32'd5000, 50);
        cls_q.push_back(4'd3);
        // Offer junk while the buffer is not ready; none of it may land
        in_valid0 = 1'b1;
        in_data0  = 32'hDEADBEEF;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL gaps_ready_low cycle %0d: got %b want 0", n, in_ready0); end
        end
        in_valid0 = 1'b0;
        while (vec_q.size() > 0) begin
            w = vec_q.pop_front();
            n_checks++;
            if (feat0[DW*w.idx +: DW] !== w.val) begin
                n_fail++; $display("FAIL gaps_vec word %0d: got %0h want %0h", w.idx, feat0[DW*w.idx +: DW], w.val);
            end
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (class_valid0) begin
                pulses++;
                if (cls_q.size() > 0) begin
                    exp_c = cls_q.pop_front();
                    n_checks++;
                    if (class_out0 !== exp_c) begin n_fail++; $display("FAIL gaps_class: got %0d want %0d", class_out0, exp_c); end
                end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL gaps_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_abort();
        word_t       w;
        logic [31:0] keep150;
        int          pulses = 0;
        class_in = 4'd12;
        stream(0, 0, 150, 32'd9000, 0);
        vec_q.delete();
        keep150 = model0[150];
        // Abort together with a valid word: the word must be dropped
        abort0    = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 32'hBAD0BAD0;
        @(posedge clk); #1;
        abort0    = 1'b0;
        in_valid0 = 1'b0;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL abort_fill_ready: got %b want 1", in_ready0); end
        n_checks++; if (feat0[DW*150 +: DW] !== keep150) begin n_fail++; $display("FAIL abort_word_dropped: got %0h want %0h", feat0[DW*150 +: DW], keep150); end
        stream(0, 0, F, 32'd20000, 0);
        while (vec_q.size() > 0) begin
            w = vec_q.pop_front();
            n_checks++;
            if (feat0[DW*w.idx +: DW] !== w.val) begin
                n_fail++; $display("FAIL abort_vec word %0d: got %0d want %0d", w.idx, feat0[DW*w.idx +: DW], w.val);
            end
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (class_valid0) begin
                pulses++;
                n_checks++;
                if (class_out0 !== 4'd12) begin n_fail++; $display("FAIL abort_class: got %0d want 12", class_out0); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL abort_pulses: got %0d want 1", pulses); end
        // Abort inside the hold window: no report afterwards
        class_in = 4'd5;
        stream(0, 0, F, 32'd30000, 0);
        vec_q.delete();
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (ann_reset0 !== 1'b0) begin n_fail++; $display("FAIL hold_ann_low: got %b want 0", ann_reset0); end
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL hold_abort_ready: got %b want 1", in_ready0); end
        n_checks++; if (ann_reset0 !== 1'b1) begin n_fail++; $display("FAIL hold_abort_ann: got %b want 1", ann_reset0); end
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (class_valid0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL hold_abort_pulses: got %0d want 0", pulses); end
        n_checks++; if (class_out0 !== 4'd12) begin n_fail++; $display("FAIL hold_abort_class_kept: got %0d want 12", class_out0); end
    endtask

    task automatic test_reset_mid();
        word_t w;
        int    pulses = 0;
        class_in = 4'd9;
        stream(0, 0, F, 32'd40000, 0);
        vec_q.delete();
        // Hold count reaches 5 six edges after the last word
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", in_ready0); end
        n_checks++; if (ann_reset0 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ann: got %b want 1", ann_reset0); end
        n_checks++; if (class_valid0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", class_valid0); end
        n_checks++; if (class_out0 !== 4'd0) begin n_fail++; $display("FAIL mid_rst_class: got %0d want 0", class_out0); end
        n_checks++; if (feat0 !== '0) begin n_fail++; $display("FAIL mid_rst_feat: not all zero"); end
        for (int i = 0; i < F; i++) model0[i] = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        stream(0, 0, F, 32'd50000, 0);
        while (vec_q.size() > 0) begin
            w = vec_q.pop_front();
            n_checks++;
            if (feat0[DW*w.idx +: DW] !== w.val) begin
                n_fail++; $display("FAIL mid_vec word %0d: got %0d want %0d", w.idx, feat0[DW*w.idx +: DW], w.val);
            end
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (class_valid0) begin
                pulses++;
                n_checks++;
                if (class_out0 !== 4'd9) begin n_fail++; $display("FAIL mid_class: got %0d want 9", class_out0); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL mid_pulses: got %0d want 1", pulses); end
    endtask

    initial begin
        reset     = 1'b1;
        in_data0  = '0;
        in_data1  = '0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        abort0    = 1'b0;
        abort1    = 1'b0;
        class_in  = 4'd0;
        for (int i = 0; i < F; i++) model0[i] = 32'd0;
        test_reset();
        test_basic();
        test_interleaved();
        test_gaps();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
